// File: rtl/data_ram_responder_pkg.sv
// Shared widths, constants and FSM encoding for the data-RAM responder.
package data_ram_responder_pkg;

  localparam int unsigned DataBus     = 32;
  localparam int unsigned DataAddrBus = 32;
  localparam int unsigned MemSel      = 4;
  localparam int unsigned WaitCntW    = 4;

  localparam logic [DataBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ram_state_e;

endpackage

// File: rtl/data_ram_bank.sv
// 2^ADDR_W x 32 storage with byte-lane write enables and a registered read port.
module data_ram_bank
  import data_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MemSel-1:0] we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DataBus-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DataBus-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DataBus-1:0] mem [Depth];

  // Byte-lane write; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int n = 0; n < int'(MemSel); n++) begin
      if (we[n]) begin
        mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

  // Read register: cleared by reset, otherwise holds until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= ZeroWord;
    end else if (rd_en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder for the MEM stage: single-cycle writes, reads with
// WAIT_CYCLES wait states and a pipeline stall while a read is in flight.
// Optional feature macro: DATA_RAM_ACCESS_CNT_EN adds rd_cnt_o / wr_cnt_o.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ram_en_i,
  input  logic                   ram_we_i,
  input  logic [MemSel-1:0]      ram_sel_i,
  input  logic [DataAddrBus-1:0] ram_addr_i,
  input  logic [DataBus-1:0]     ram_wdata_i,
  output logic [DataBus-1:0]     ram_rdata_o,
  output logic                   stall_req_o
`ifdef DATA_RAM_ACCESS_CNT_EN
  ,
  output logic [31:0]            rd_cnt_o,
  output logic [31:0]            wr_cnt_o
`endif
);

  ram_state_e          state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   word_idx;
  logic [MemSel-1:0]   bank_we;
  logic                rd_en;
  logic                unused_addr;

  // Upper bits alias; the byte offset is always zero from MEM.
  assign word_idx    = ram_addr_i[ADDR_W+1:2];
  assign unused_addr = ^{ram_addr_i[DataAddrBus-1:ADDR_W+2], ram_addr_i[1:0]};

  // State, wait counter and captured read index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, stall request and array strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stall_req_o = 1'b0;
    bank_we     = '0;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_en_i) begin
          if (ram_we_i) begin
            bank_we = ram_sel_i;
          end else begin
            stall_req_o = 1'b1;
            idx_d       = word_idx;
            cnt_d       = WaitCntW'(WAIT_CYCLES);
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        stall_req_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WaitCntW'(1);
        end else begin
          rd_en   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // No array access during a reset cycle.
    if (reset) begin
      bank_we = '0;
      rd_en   = 1'b0;
    end
  end

  data_ram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we),
    .waddr (word_idx),
    .wdata (ram_wdata_i),
    .rd_en (rd_en),
    .raddr (idx_q),
    .rdata (ram_rdata_o)
  );

`ifdef DATA_RAM_ACCESS_CNT_EN
  // Access counters: reads counted on entry to DONE, writes when any lane is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (rd_en) begin
        rd_cnt_o <= rd_cnt_o + 32'd1;
      end
      if (bank_we != '0) begin
        wr_cnt_o <= wr_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (2 and 0 wait states),
// directed vector table, reset and counter sequences, random traffic vs. a model.
module tb_data_ram_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned WC0 = 2;
  localparam int unsigned WC1 = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        en    [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
`ifdef DATA_RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt [2];
  logic [31:0] wr_cnt [2];
`endif

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] mdl [2][4096];
  int wr_exp [2];
  int rd_exp [2];

  typedef struct {
    int          d;
    bit          is_wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .reset(reset), .ram_en_i(en[0]), .ram_we_i(we[0]), .ram_sel_i(sel[0]),
    .ram_addr_i(addr[0]), .ram_wdata_i(wdata[0]), .ram_rdata_o(rdata[0]), .stall_req_o(stall[0])
`ifdef DATA_RAM_ACCESS_CNT_EN
    , .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0])
`endif
  );

  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .reset(reset), .ram_en_i(en[1]), .ram_we_i(we[1]), .ram_sel_i(sel[1]),
    .ram_addr_i(addr[1]), .ram_wdata_i(wdata[1]), .ram_rdata_o(rdata[1]), .stall_req_o(stall[1])
`ifdef DATA_RAM_ACCESS_CNT_EN
    , .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input int d, input bit is_wr, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] e, input string name);
    vec_t v;
    v.d = d; v.is_wr = is_wr; v.sel = s; v.addr = a; v.wdata = w; v.exp = e; v.name = name;
    tbl.push_back(v);
  endtask

  // Write occupies one cycle; the model merges the selected bytes.
  task automatic do_write(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    logic [31:0] mask;
    int i;
    en[d] = 1'b1; we[d] = 1'b1; sel[d] = s; addr[d] = a; wdata[d] = w;
    #1;
    check($sformatf("wr_stall_d%0d", d), 32'(stall[d]), 32'd0);
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    i = int'(a[AW+1:2]);
    mdl[d][i] = (mdl[d][i] & ~mask) | (w & mask);
    if (s != 4'd0) wr_exp[d]++;
    @(posedge clk); #1;
    en[d] = 1'b0; we[d] = 1'b0;
  endtask

  // Read: count stalled cycles, check data in the stall-drop cycle and that it holds.
  task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp, input string name);
    int n;
    int unsigned wc;
    wc = (d == 0) ? WC0 : WC1;
    en[d] = 1'b1; we[d] = 1'b0; addr[d] = a; sel[d] = 4'($urandom); wdata[d] = $urandom;
    #1;
    n = 0;
    while (stall[d] && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(wc + 2));
    check({name, "_data"}, rdata[d], exp);
    rd_exp[d]++;
    en[d] = 1'b0;
    @(posedge clk); #1;
    check({name, "_hold"}, rdata[d], exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pool [16];
    int k;
    logic [31:0] a;

    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; addr[d] = '0; wdata[d] = '0;
      wr_exp[d] = 0; rd_exp[d] = 0;
    end
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_rdata_d%0d", d), rdata[d], 32'h0);
      check($sformatf("reset_stall_d%0d", d), 32'(stall[d]), 32'd0);
    end

    // Directed vectors.
    add(0, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         "");
    add(0, 0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "word_rd");
    add(0, 1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0,         "");
    add(0, 1, 4'h4, 32'h0000_0020, 32'hAAAA_AAAA, 32'h0,         "");
    add(0, 0, 4'h0, 32'h0000_0020, 32'h0,         32'h11AA_3344, "lane_merge");
    add(0, 1, 4'hF, 32'h0000_4004, 32'h5A5A_5A5A, 32'h0,         "");
    add(0, 0, 4'h0, 32'h0000_0004, 32'h0,         32'h5A5A_5A5A, "alias");
    add(0, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         "");
    add(0, 0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "sel_zero");
    add(0, 1, 4'h3, 32'h0000_0010, 32'h0000_CAFE, 32'h0,         "");
    add(0, 0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_CAFE, "low_lanes");
    add(1, 1, 4'hF, 32'h0000_0000, 32'h0102_0304, 32'h0,         "");
    add(1, 1, 4'hF, 32'h0000_0004, 32'hA0B0_C0D0, 32'h0,         "");
    add(1, 0, 4'h0, 32'h0000_0000, 32'h0,         32'h0102_0304, "w0_rd0");
    add(1, 0, 4'h0, 32'h0000_0004, 32'h0,         32'hA0B0_C0D0, "w0_rd4");
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].d, tbl[i].addr, tbl[i].sel, tbl[i].wdata);
      else              do_read(tbl[i].d, tbl[i].addr, tbl[i].exp, tbl[i].name);
    end

    // Reset while a read is waiting.
    do_write(0, 32'h0000_0008, 4'hF, 32'hC0FF_EE00);
    en[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0008;
    #1;
    check("rst_req_stall", 32'(stall[0]), 32'd1);
    @(posedge clk); #1;
    check("rst_wait_stall", 32'(stall[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    en[0] = 1'b0;
    #1;
    check("rst_stall", 32'(stall[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'h0);
    for (int d = 0; d < 2; d++) begin
      wr_exp[d] = 0; rd_exp[d] = 0;
    end

    // Counter sequence: three writes (one empty) and two reads.
    do_write(0, 32'h0000_0030, 4'hF, 32'h1357_9BDF);
    do_write(0, 32'h0000_0034, 4'h0, 32'hFFFF_FFFF);
    do_write(0, 32'h0000_0038, 4'h2, 32'h0000_7700);
    do_read(0, 32'h0000_0030, 32'h1357_9BDF, "cnt_rd0");
    do_read(0, 32'h0000_0038, mdl[0][14], "cnt_rd1");
`ifdef DATA_RAM_ACCESS_CNT_EN
    check("cnt_wr", wr_cnt[0], 32'd2);
    check("cnt_rd", rd_cnt[0], 32'd2);
`endif
    do_read(0, 32'h0000_0008, 32'hC0FF_EE00, "rst_readback");

    // Random traffic against the model, including aliased upper address bits.
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 16; p++) begin
        pool[p] = int'($urandom_range(4095));
        do_write(d, {18'($urandom), 12'(pool[p]), 2'b00}, 4'hF, $urandom);
      end
      for (int t = 0; t < 120; t++) begin
        k = int'($urandom_range(15));
        a = {18'($urandom), 12'(pool[k]), 2'b00};
        if ($urandom_range(1) == 1) do_write(d, a, 4'($urandom), $urandom);
        else                        do_read(d, a, mdl[d][pool[k]], $sformatf("rand_d%0d_t%0d", d, t));
      end
`ifdef DATA_RAM_ACCESS_CNT_EN
      check($sformatf("final_wr_cnt_d%0d", d), wr_cnt[d], 32'(wr_exp[d]));
      check($sformatf("final_rd_cnt_d%0d", d), rd_cnt[d], 32'(rd_exp[d]));
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
